// File: rtl/conf_int_mul__apx_pipe__w_wrapper_if.sv
// Operand/result bundle for the approximate multiplier wrapper.
// The master drives the operands and the result-side ready; the slave (the multiplier)
// drives the results and the operand-side ready.
interface conf_int_mul__apx_pipe__w_wrapper_if #(
  parameter int unsigned DATA_PATH_BITWIDTH__A = 24,
  parameter int unsigned DATA_PATH_BITWIDTH__B = 24
);
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_PATH_BITWIDTH__A-1:0] A_in_to_wrapper;
  logic [DATA_PATH_BITWIDTH__B-1:0] B_in_to_wrapper;
  logic [1:0]                       apx_lvl;
  logic [2:0]                       state_in_to_wrapper;
  logic                             out_valid;
  logic                             out_ready;
  logic [31:0]                      P;
  logic [2:0]                       state_out_of_wrapper;
  logic                             sat_flag;
  logic [15:0]                      op_cnt;

  modport master (
    output in_valid, A_in_to_wrapper, B_in_to_wrapper, apx_lvl, state_in_to_wrapper, out_ready,
    input  in_ready, out_valid, P, state_out_of_wrapper, sat_flag, op_cnt
  );

  modport slave (
    input  in_valid, A_in_to_wrapper, B_in_to_wrapper, apx_lvl, state_in_to_wrapper, out_ready,
    output in_ready, out_valid, P, state_out_of_wrapper, sat_flag, op_cnt
  );
endinterface

// File: rtl/conf_int_mul__apx_pipe__w_wrapper.sv
// Configurable-precision signed multiplier with a globally stalled pipeline.
// Stages: operand register, MUL_STAGES product registers, then a windowed/saturated
// output register. A 3-bit tag rides alongside each operation.
module conf_int_mul__apx_pipe__w_wrapper #(
  parameter int unsigned OP_BITWIDTH           = 16,
  parameter int unsigned DATA_PATH_BITWIDTH__A = 24,
  parameter int unsigned DATA_PATH_BITWIDTH__B = 24,
  parameter int unsigned MUL_STAGES            = 2,
  parameter int unsigned TRUNC_STEP            = 4,
  parameter int unsigned OUT_LSB               = 6,
  parameter int unsigned SAT                   = 1
) (
  input logic clk,
  input logic rstN,
  conf_int_mul__apx_pipe__w_wrapper_if.slave bus
);

  localparam int unsigned WA     = DATA_PATH_BITWIDTH__A;
  localparam int unsigned WB     = DATA_PATH_BITWIDTH__B;
  localparam int unsigned PW     = WA + WB;
  localparam int unsigned WinTop = OUT_LSB + 31;
  // Wide enough to hold both the product and the window top bit.
  localparam int unsigned EW     = (PW > WinTop + 1) ? PW : WinTop + 1;

  logic                 adv;
  logic [31:0]          trunc_bits;
  logic [WA-1:0]        a_mask;
  logic [WB-1:0]        b_mask;
  logic signed [EW-1:0] ext;
  logic                 ovf;
  logic [31:0]          p_win;

  logic signed [WA-1:0] a_q, a_d;
  logic signed [WB-1:0] b_q, b_d;
  logic                 v0_q, v0_d;
  logic [2:0]           tag0_q, tag0_d;

  logic signed [PW-1:0] prod_q [MUL_STAGES];
  logic signed [PW-1:0] prod_d [MUL_STAGES];
  logic [2:0]           ptag_q [MUL_STAGES];
  logic [2:0]           ptag_d [MUL_STAGES];
  logic [MUL_STAGES-1:0] pv_q, pv_d;

  logic        ov_q, ov_d;
  logic [31:0] p_q, p_d;
  logic [2:0]  otag_q, otag_d;
  logic        sat_q, sat_d;
  logic [15:0] cnt_q, cnt_d;

  // Operand masking, output windowing/saturation and pipeline next-state.
  always_comb begin
    adv = ~ov_q | bus.out_ready;

    // Zeroed LSB count is capped at the operator precision.
    trunc_bits = 32'(bus.apx_lvl) * TRUNC_STEP;
    if (trunc_bits > OP_BITWIDTH) trunc_bits = OP_BITWIDTH;
    a_mask = {WA{1'b1}} << trunc_bits;
    b_mask = {WB{1'b1}} << trunc_bits;

    ext   = prod_q[MUL_STAGES-1];
    // Overflow when the bits from the window top upward are not a pure sign extension.
    ovf   = (SAT != 0) && !((&ext[EW-1:WinTop]) || ~(|ext[EW-1:WinTop]));
    p_win = ovf ? (ext[EW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : ext[WinTop:OUT_LSB];

    a_d    = a_q;
    b_d    = b_q;
    v0_d   = v0_q;
    tag0_d = tag0_q;
    prod_d = prod_q;
    ptag_d = ptag_q;
    pv_d   = pv_q;
    ov_d   = ov_q;
    p_d    = p_q;
    otag_d = otag_q;
    sat_d  = sat_q;

    if (adv) begin
      v0_d   = bus.in_valid;
      a_d    = bus.A_in_to_wrapper & a_mask;
      b_d    = bus.B_in_to_wrapper & b_mask;
      tag0_d = bus.state_in_to_wrapper;

      prod_d[0] = a_q * b_q;
      ptag_d[0] = tag0_q;
      pv_d[0]   = v0_q;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_d[i] = prod_q[i-1];
        ptag_d[i] = ptag_q[i-1];
        pv_d[i]   = pv_q[i-1];
      end

      ov_d   = pv_q[MUL_STAGES-1];
      p_d    = p_win;
      otag_d = ptag_q[MUL_STAGES-1];
      sat_d  = ovf;
    end

    cnt_d = cnt_q;
    if (ov_q && bus.out_ready && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q    <= '0;
      b_q    <= '0;
      v0_q   <= 1'b0;
      tag0_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
        ptag_q[i] <= '0;
      end
      pv_q   <= '0;
      ov_q   <= 1'b0;
      p_q    <= '0;
      otag_q <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      v0_q   <= v0_d;
      tag0_q <= tag0_d;
      prod_q <= prod_d;
      ptag_q <= ptag_d;
      pv_q   <= pv_d;
      ov_q   <= ov_d;
      p_q    <= p_d;
      otag_q <= otag_d;
      sat_q  <= sat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready             = adv;
  assign bus.out_valid            = ov_q;
  assign bus.P                    = p_q;
  assign bus.state_out_of_wrapper = otag_q;
  assign bus.sat_flag             = sat_q;
  assign bus.op_cnt               = cnt_q;

endmodule

// File: tb/tb_conf_int_mul__apx_pipe__w_wrapper.sv
// Directed bench for the approximate multiplier wrapper (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_conf_int_mul__apx_pipe__w_wrapper;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  conf_int_mul__apx_pipe__w_wrapper_if #(
    .DATA_PATH_BITWIDTH__A(24),
    .DATA_PATH_BITWIDTH__B(24)
  ) bus ();

  conf_int_mul__apx_pipe__w_wrapper dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // Drive one operation and wait for its result; returns observed outputs and edge count.
  task automatic send_one(input logic [23:0] a, input logic [23:0] b, input logic [1:0] l,
                          input logic [2:0] tag, output logic [31:0] p, output logic [2:0] t,
                          output logic s, output int lat);
    bus.A_in_to_wrapper = a;
    bus.B_in_to_wrapper = b;
    bus.apx_lvl = l;
    bus.state_in_to_wrapper = tag;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 20);
    p = bus.P;
    t = bus.state_out_of_wrapper;
    s = bus.sat_flag;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.P !== 32'h0) begin
      n_bad++; $display("FAIL reset_P: got %h expected 00000000", bus.P);
    end
    n_cmp++;
    if (bus.op_cnt !== 16'h0 || bus.sat_flag !== 1'b0 || bus.state_out_of_wrapper !== 3'b0) begin
      n_bad++;
      $display("FAIL reset_misc: got cnt=%h sat=%b tag=%b expected 0000/0/000",
               bus.op_cnt, bus.sat_flag, bus.state_out_of_wrapper);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_exact();
    logic [31:0] p; logic [2:0] t; logic s; int lat;
    send_one(24'h00010F, 24'h000203, 2'd0, 3'b010, p, t, s, lat);
    n_cmp++;
    if (p !== 32'h00000884) begin n_bad++; $display("FAIL exact_P: got %h expected 00000884", p); end
    n_cmp++;
    if (t !== 3'b010) begin n_bad++; $display("FAIL exact_tag: got %b expected 010", t); end
    n_cmp++;
    if (s !== 1'b0) begin n_bad++; $display("FAIL exact_sat: got %b expected 0", s); end
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL exact_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_approx();
    logic [31:0] exp_p [3] = '{32'h00000800, 32'h00000800, 32'h00000000};
    logic [31:0] p; logic [2:0] t; logic s; int lat;
    for (int l = 1; l <= 3; l++) begin
      send_one(24'h00010F, 24'h000203, 2'(l), 3'(l), p, t, s, lat);
      n_cmp++;
      if (p !== exp_p[l-1] || t !== 3'(l)) begin
        n_bad++;
        $display("FAIL approx_L%0d: got P=%h tag=%b expected P=%h tag=%b", l, p, t, exp_p[l-1],
                 3'(l));
      end
    end
  endtask

  task automatic test_signed_sat();
    logic [23:0] va [6] = '{24'hFFFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'hE00000, 24'h200000, 24'hFFFFFF};
    logic [23:0] vb [6] = '{24'hFFFFC0, 24'h7FFFFF, 24'h800000, 24'h010000, 24'h010000, 24'h000001};
    logic [31:0] ep [6] = '{32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                            32'hFFFFFFFF};
    logic        es [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] p; logic [2:0] t; logic s; int lat;
    for (int i = 0; i < 6; i++) begin
      send_one(va[i], vb[i], 2'd0, 3'(i + 1), p, t, s, lat);
      n_cmp++;
      if (p !== ep[i] || s !== es[i] || t !== 3'(i + 1)) begin
        n_bad++;
        $display("FAIL signed_sat_%0d: got P=%h sat=%b tag=%b expected P=%h sat=%b tag=%b",
                 i, p, s, t, ep[i], es[i], 3'(i + 1));
      end
    end
  endtask

  // Eight ops back to back; consumer stalls during cycles 5..9.
  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stalls = 0;
    logic [31:0] hold_p;
    logic [2:0] hold_t;
    do_reset();
    for (int c = 0; c < 60 && got < 8; c++) begin
      bus.out_ready = !(c >= 5 && c <= 9);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
          n_bad++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", c, bus.in_ready);
        end
        if (c == 5) begin
          hold_p = bus.P;
          hold_t = bus.state_out_of_wrapper;
        end else begin
          n_cmp++;
          if (bus.P !== hold_p || bus.state_out_of_wrapper !== hold_t) begin
            n_bad++;
            $display("FAIL stall_hold: cycle %0d got P=%h tag=%b expected P=%h tag=%b", c,
                     bus.P, bus.state_out_of_wrapper, hold_p, hold_t);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (bus.P !== 32'((got + 1) * (got + 3)) ||
            bus.state_out_of_wrapper !== (3'(got) ^ 3'b101)) begin
          n_bad++;
          $display("FAIL stream_out_%0d: got P=%h tag=%b expected P=%h tag=%b", got, bus.P,
                   bus.state_out_of_wrapper, 32'((got + 1) * (got + 3)), 3'(got) ^ 3'b101);
        end
        got++;
      end
      if (sent < 8) begin
        bus.A_in_to_wrapper = 24'(sent + 1);
        bus.B_in_to_wrapper = 24'(64 * (sent + 3));
        bus.apx_lvl = 2'd0;
        bus.state_in_to_wrapper = 3'(sent) ^ 3'b101;
        bus.in_valid = 1'b1;
        if (bus.in_ready) sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (got != 8) begin n_bad++; $display("FAIL stream_count: got %0d expected 8", got); end
    n_cmp++;
    if (stalls != 5) begin n_bad++; $display("FAIL stream_stalls: got %0d expected 5", stalls); end
    n_cmp++;
    if (bus.op_cnt !== 16'd8) begin
      n_bad++; $display("FAIL stream_op_cnt: got %0d expected 8", bus.op_cnt);
    end
  endtask

  // Three ops in flight, first one parked at the output, then reset.
  task automatic test_reset_midflight();
    int seen = 0;
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.A_in_to_wrapper = 24'h000100;
      bus.B_in_to_wrapper = 24'h000100 + 24'(c);
      bus.apx_lvl = 2'd0;
      bus.state_in_to_wrapper = 3'b111;
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.P !== 32'h00000400) begin
      n_bad++;
      $display("FAIL midflight_pre: got valid=%b P=%h expected valid=1 P=00000400",
               bus.out_valid, bus.P);
    end
    rstN = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.P !== 32'h0 || bus.state_out_of_wrapper !== 3'b0) begin
      n_bad++;
      $display("FAIL midflight_async_clear: got valid=%b P=%h tag=%b expected 0/00000000/000",
               bus.out_valid, bus.P, bus.state_out_of_wrapper);
    end
    @(negedge clk);
    rstN = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL midflight_no_valid: got %0d expected 0", seen); end
    n_cmp++;
    if (bus.op_cnt !== 16'd0) begin
      n_bad++; $display("FAIL midflight_op_cnt: got %0d expected 0", bus.op_cnt);
    end
  endtask

  task automatic test_counter_sat();
    int hs = 0;
    do_reset();
    bus.A_in_to_wrapper = 24'h000040;
    bus.B_in_to_wrapper = 24'h000003;
    bus.apx_lvl = 2'd0;
    bus.state_in_to_wrapper = 3'b001;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 70000 && hs < 65537; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (hs == 65534 || hs == 65535 || hs == 65536) begin
          n_cmp++;
          if (bus.op_cnt !== ((hs >= 65535) ? 16'hFFFF : 16'hFFFE)) begin
            n_bad++;
            $display("FAIL cnt_at_%0d: got %h expected %h", hs, bus.op_cnt,
                     (hs >= 65535) ? 16'hFFFF : 16'hFFFE);
          end
        end
        hs++;
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (hs != 65537) begin n_bad++; $display("FAIL cnt_completions: got %0d expected 65537", hs); end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (bus.op_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL cnt_saturated: got %h expected FFFF", bus.op_cnt);
    end
  endtask

  initial begin
    rstN = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A_in_to_wrapper = '0;
    bus.B_in_to_wrapper = '0;
    bus.apx_lvl = '0;
    bus.state_in_to_wrapper = '0;
    test_reset();
    test_exact();
    test_approx();
    test_signed_sat();
    test_back_to_back();
    test_reset_midflight();
    test_counter_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conf_int_mul__apx_pipe__w_wrapper.md
Name: conf_int_mul__apx_pipe__w_wrapper

Overview:
- Parametrised successor to the single-stage configurable-precision multiplier wrapper used in the IDCT datapath.
- Accepts signed A/B operands over a valid/ready handshake and applies a per-transaction approximation level, selected at run time, that zeroes operand LSB chunks.
- Multiplies through a configurable-depth pipeline and returns a windowed, optionally saturated 32-bit product.
- Carries a 3-bit state tag alongside each operation so the IDCT controller can realign results without external bookkeeping.

Parameters:
- OP_BITWIDTH, 16, operator precision in bits; informational, used to bound TRUNC_STEP.
- DATA_PATH_BITWIDTH__A, 24, width of operand A.
- DATA_PATH_BITWIDTH__B, 24, width of operand B.
- MUL_STAGES, 2, product register stages after the input register; 1..4.
- TRUNC_STEP, 4, LSBs zeroed per approximation level; 3*TRUNC_STEP must not exceed min(A,B width).
- OUT_LSB, 6, product bit mapped to P[0].
- SAT, 1, 1 = saturate on window overflow; 0 = plain truncation.

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- A_in_to_wrapper  in  DATA_PATH_BITWIDTH__A  signed operand A.
- B_in_to_wrapper  in  DATA_PATH_BITWIDTH__B  signed operand B.
- apx_lvl  in  2  approximation level, sampled with the operands.
- state_in_to_wrapper  in  3  tag, sampled with the operands.
- out_valid  out  1  P valid.
- out_ready  in  1  consumer accepts P.
- P  out  32  windowed product.
- state_out_of_wrapper  out  3  tag aligned with P.
- sat_flag  out  1  the current P was saturated.
- op_cnt  out  16  completed-transaction count; saturates at 0xFFFF.

Behaviour:
- Reset (rstN=0, asynchronous): all valid bits 0; P, tags, sat_flag, op_cnt and pipeline data all 0; in_ready=1 one cycle after release.
- Global-stall pipeline: adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=1, every stage shifts, including bubbles.
  - When adv=0, all stage registers hold.
  - No combinational path from in_valid to out_valid.
- Accept: in_valid & in_ready at an edge.
- Stage 0 registers the operands, tag and valid.
  - apx_lvl=L zeroes bits [L*TRUNC_STEP-1:0] of both A and B.
  - L=0 is exact.
- Product: full signed A*B, width A+B, computed in the first product stage and carried through the remaining MUL_STAGES-1 stages.
- Window: W = product[OUT_LSB+31:OUT_LSB], arithmetic, so the low bits are floored.
  - With SAT=1, if the product bits above OUT_LSB+31 are not all equal to product[OUT_LSB+31], P = 0x7FFFFFFF for a positive product or 0x80000000 for a negative one, and sat_flag=1.
  - Otherwise P=W and sat_flag=0.
- Latency: MUL_STAGES+2 edges from accept to out_valid=1 when there is no backpressure. Default = 4.
- Throughput: one operation per cycle when out_ready=1.
- out_valid & ~out_ready: P, the tag and sat_flag hold stable until accepted.
- Simultaneous accept and drain in one cycle is legal; no data loss or duplication.
- op_cnt increments on each out_valid & out_ready and holds at 0xFFFF.
- Reset asserted mid-operation discards all in-flight operations immediately; no out_valid afterwards for them.
- Operations and tags leave strictly in order.

Test Plan:
- Exact multiply: A=0x00010F, B=0x000203, L=0, tag=3'b010 → P=0x00000884, tag 3'b010, sat_flag=0, 4 cycles after accept.
- Approximation: same operands, L=1 → A=0x100, B=0x200 → P=0x00000800; L=3 with TRUNC_STEP=4 → A=0, B=0 → P=0.
- Signed and saturation:
  - A=0xFFFFFF, B=0xFFFFC0, L=0 → P=1.
  - A=B=0x7FFFFF → P=0x7FFFFFFF, sat_flag=1.
  - A=0x7FFFFF, B=0x800000 → P=0x80000000, sat_flag=1.
- Backpressure: stream 8 operations back to back, with out_ready low for cycles 5–9 → P holds, in_ready=0 during the stall, all 8 results emerge in order with correct tags, op_cnt=8.
- Reset mid-flight: accept 3 operations, pull rstN low for 1 cycle at cycle 2 → outputs clear asynchronously, no out_valid for the 3, op_cnt=0.
- Counter saturation: force 65537 completions → op_cnt=0xFFFF.
